// File: rtl/draw_player_anim_pkg.sv
// Shared types for the animated player overlay: control state,
// animation step, facing, VGA pixel bundle and pipeline stage struct.
package draw_player_anim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RIGHT1,
    LEFT1,
    RIGHT2,
    LEFT2
  } State;

  typedef enum logic [1:0] {
    STAND  = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2,
    TURN   = 2'd3
  } anim_step_t;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } facing_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t        vga;
    logic [12:0] rx;
    logic [12:0] ry;
    logic        in_box;
  } s1_t;

  function automatic logic in_rng(
    input logic [12:0] v,
    input logic [12:0] lo,
    input logic [12:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/draw_player_anim_if.sv
// VGA stream bundle: timing counters, sync/blank flags and rgb.
// master drives the stream, slave receives it.
interface draw_player_anim_if;
  logic [11:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, hsync, hblnk,
    output vcount, vsync, vblnk, rgb
  );

  modport slave (
    input hcount, hsync, hblnk,
    input vcount, vsync, vblnk, rgb
  );
endinterface

// File: rtl/draw_player_anim_fsm.sv
// Frame tick, facing memory, walk-cycle FSM and (DRAW_PLAYER_BLINK_EN)
// blink counter. Ports: clk, rst_n, vblnk_s1, state -> anim_step, facing, blink.
module draw_player_anim_fsm
  import draw_player_anim_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk_s1,
  input  State       state,
  output anim_step_t anim_step,
  output facing_t    facing,
  output logic       blink
);

  localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

  logic       vblnk_d;
  logic       tick;
  logic       moving;
  anim_step_t step_q, step_d;
  facing_t    face_q, face_d, req;
  logic [7:0] cnt_q, cnt_d;
`ifdef DRAW_PLAYER_BLINK_EN
  logic [6:0] blk_q;
`endif

  // Rising edge of the stage-1 blank: one pulse per frame.
  assign tick = vblnk_s1 & ~vblnk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d <= 1'b0;
      step_q  <= STAND;
      face_q  <= RIGHT;
      cnt_q   <= '0;
`ifdef DRAW_PLAYER_BLINK_EN
      blk_q   <= '0;
`endif
    end else begin
      vblnk_d <= vblnk_s1;
      step_q  <= step_d;
      face_q  <= face_d;
      cnt_q   <= cnt_d;
`ifdef DRAW_PLAYER_BLINK_EN
      blk_q   <= blk_q + 7'(tick);
`endif
    end
  end

  always_comb begin
    moving = (state == RIGHT1) || (state == LEFT1);
    unique case (state)
      RIGHT1, RIGHT2: req = RIGHT;
      LEFT1, LEFT2:   req = LEFT;
      default:        req = face_q;
    endcase
    step_d = step_q;
    face_d = face_q;
    cnt_d  = cnt_q;
    if (tick) begin
      if (req != face_q) begin
        face_d = req;
        step_d = TURN;
        cnt_d  = '0;
      end else begin
        unique case (step_q)
          STAND, TURN: begin
            step_d = moving ? WALK_A : STAND;
            cnt_d  = '0;
          end
          WALK_A, WALK_B: begin
            if (!moving) begin
              step_d = STAND;
              cnt_d  = '0;
            end else if (cnt_q == LAST) begin
              step_d = (step_q == WALK_A) ? WALK_B : WALK_A;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    anim_step = step_q;
    facing    = face_q;
`ifdef DRAW_PLAYER_BLINK_EN
    blink = (blk_q >= 7'd124) && (step_q == STAND);
`else
    blink = 1'b0;
`endif
  end

endmodule

// File: rtl/draw_player_anim.sv
// Animated player sprite overlay, 2-cycle pixel pipeline (optional DRAW_PLAYER_BLINK_EN).
// Ports: clk, rst_n, vga_in/vga_out (VGA bundle), xpos, ypos, state -> anim_step.
module draw_player_anim
  import draw_player_anim_pkg::*;
#(
  parameter int          SPRITE_W        = 40,
  parameter int          SPRITE_H        = 90,
  parameter int          BASE_Y          = 410,
  parameter logic [11:0] BODY_RGB        = 12'hF0F,
  parameter logic [11:0] EYE_RGB         = 12'h0FF,
  parameter int          FRAMES_PER_STEP = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  draw_player_anim_if.slave  vga_in,
  draw_player_anim_if.master vga_out,
  input  logic [11:0]        xpos,
  input  logic [11:0]        ypos,
  input  State               state,
  output logic [1:0]         anim_step
);

  localparam logic signed [13:0] W14  = 14'(SPRITE_W);
  localparam logic signed [13:0] H14  = 14'(SPRITE_H);
  localparam logic signed [13:0] BY14 = 14'(BASE_Y);
  localparam logic [12:0]        W    = 13'(SPRITE_W);
  localparam logic [12:0]        H    = 13'(SPRITE_H);

  vga_t              px_in;
  logic signed [13:0] rx_w, ry_w;
  logic              in_box;
  s1_t               s1_q;
  vga_t              s2_d, s2_q;
  anim_step_t        step;
  facing_t           facing;
  logic              blink;
  logic [12:0]       ux, uy, mx, lhi, rlo;
  logic              walk, eye, fill;

  assign px_in = '{
    hcount: vga_in.hcount, hsync: vga_in.hsync,
    hblnk:  vga_in.hblnk,  vcount: vga_in.vcount,
    vsync:  vga_in.vsync,  vblnk: vga_in.vblnk,
    rgb:    vga_in.rgb
  };

  // One extra bit over the stored 13 so large offsets cannot wrap into the box.
  assign rx_w = $signed({2'b00, vga_in.hcount})
              - $signed({2'b00, xpos});
  assign ry_w = $signed({2'b00, vga_in.vcount})
              - $signed({2'b00, ypos}) - BY14;
  assign in_box = (rx_w >= 14'sd0) && (rx_w < W14)
               && (ry_w >= 14'sd0) && (ry_w < H14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.vga    <= px_in;
      s1_q.rx     <= rx_w[12:0];
      s1_q.ry     <= ry_w[12:0];
      s1_q.in_box <= in_box;
    end
  end

  draw_player_anim_fsm #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk_s1  (s1_q.vga.vblnk),
    .state     (state),
    .anim_step (step),
    .facing    (facing),
    .blink     (blink)
  );

  always_comb begin
    ux   = s1_q.rx;
    uy   = s1_q.ry;
    mx   = (facing == LEFT) ? (W - 13'd1 - ux) : ux;
    walk = (step == WALK_A) || (step == WALK_B);
    // Shifted legs clip at the box edge, so only one bound moves.
    lhi  = (step == WALK_A) ? 13'd10 : 13'd14;
    rlo  = (step == WALK_B) ? (W - 13'd11) : (W - 13'd15);
    if (walk) begin
      eye = in_rng(uy, 13'd20, 13'd39)
         && in_rng(mx, W - 13'd5, W - 13'd1);
    end else begin
      eye = in_rng(uy, 13'd26, 13'd33)
         && (in_rng(ux, 13'd6, 13'd13)
          || in_rng(ux, W - 13'd14, W - 13'd7));
    end
    fill = (in_rng(uy, 13'd0, 13'd4)
            && (in_rng(ux, 13'd0, 13'd9)
             || in_rng(ux, W - 13'd10, W - 13'd1)))
        || (in_rng(uy, 13'd5, 13'd9)
            && (in_rng(ux, 13'd0, 13'd14)
             || in_rng(ux, W - 13'd15, W - 13'd1)))
        || (in_rng(uy, 13'd10, H - 13'd21)
            && (!walk || mx <= W - 13'd6))
        || (in_rng(uy, H - 13'd20, H - 13'd1)
            && (in_rng(ux, 13'd0, lhi)
             || in_rng(ux, rlo, W - 13'd1)));
    s2_d = s1_q.vga;
    if (s1_q.in_box && !s1_q.vga.hblnk && !s1_q.vga.vblnk) begin
      if (eye) begin
        s2_d.rgb = blink ? BODY_RGB : EYE_RGB;
      end else if (fill) begin
        s2_d.rgb = BODY_RGB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else begin
      s2_q <= s2_d;
    end
  end

  assign vga_out.hcount = s2_q.hcount;
  assign vga_out.hsync  = s2_q.hsync;
  assign vga_out.hblnk  = s2_q.hblnk;
  assign vga_out.vcount = s2_q.vcount;
  assign vga_out.vsync  = s2_q.vsync;
  assign vga_out.vblnk  = s2_q.vblnk;
  assign vga_out.rgb    = s2_q.rgb;
  assign anim_step      = step;

endmodule

// File: tb/tb_draw_player_anim.sv
// Scoreboard bench for draw_player_anim: random pixels around the sprite,
// reference sprite/animation model, monitor compares 2 cycles later.
module tb_draw_player_anim;
  import draw_player_anim_pkg::*;

  localparam int          W    = 40;
  localparam int          H    = 90;
  localparam int          BY   = 410;
  localparam int          FPS  = 8;
  localparam logic [11:0] BODY = 12'hF0F;
  localparam logic [11:0] EYE  = 12'h0FF;
  localparam int          NF   = 136;
  localparam int          NP   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] xpos, ypos;
  State        st;
  logic [1:0]  anim_step;

  draw_player_anim_if vin ();
  draw_player_anim_if vout ();

  draw_player_anim dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_in    (vin),
    .vga_out   (vout),
    .xpos      (xpos),
    .ypos      (ypos),
    .state     (st),
    .anim_step (anim_step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] hc, vc, rgb;
    logic        hs, hb, vs, vb;
    int          step;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: facing 0=right 1=left, step 0..3, walk tick count.
  int m_xp, m_yp, m_step, m_face, m_w, m_blk;

  function automatic bit btw(int v, int lo, int hi);
    return v >= lo && v <= hi;
  endfunction

  function automatic logic [11:0] model_rgb(
    int hc, int vc, bit hb, bit vb, logic [11:0] bg);
    int rx, ry, mx, ll, lh, rl, rh;
    bit walk, eye, fill, blk;
    if (hb || vb) return bg;
    rx = hc - m_xp;
    ry = vc - (BY + m_yp);
    if (rx < 0 || rx >= W || ry < 0 || ry >= H) return bg;
    mx = m_face ? W - 1 - rx : rx;
    walk = (m_step == 1) || (m_step == 2);
    if (walk)
      eye = btw(ry, 20, 39) && btw(mx, W - 5, W - 1);
    else
      eye = btw(ry, 26, 33)
         && (btw(rx, 6, 13) || btw(rx, W - 14, W - 7));
    ll = 0; lh = 14; rl = W - 15; rh = W - 1;
    if (m_step == 1) begin ll -= 4; lh -= 4; end
    if (m_step == 2) begin rl += 4; rh += 4; end
    fill = (btw(ry, 0, 4) && (rx <= 9 || rx >= W - 10))
        || (btw(ry, 5, 9) && (rx <= 14 || rx >= W - 15))
        || (btw(ry, 10, H - 21) && (!walk || mx <= W - 6))
        || (btw(ry, H - 20, H - 1)
            && (btw(rx, ll, lh) || btw(rx, rl, rh)));
`ifdef DRAW_PLAYER_BLINK_EN
    blk = (m_blk >= 124) && (m_step == 0);
`else
    blk = 1'b0;
`endif
    if (eye) return blk ? BODY : EYE;
    if (fill) return BODY;
    return bg;
  endfunction

  // Walk phase follows from ticks spent walking: FPS ticks per step.
  task automatic model_tick(State s);
    int req;
    bit mv;
    mv = (s == RIGHT1) || (s == LEFT1);
    if (s == RIGHT1 || s == RIGHT2) req = 0;
    else if (s == LEFT1 || s == LEFT2) req = 1;
    else req = m_face;
    m_blk = (m_blk + 1) % 128;
    if (req != m_face) begin
      m_face = req;
      m_step = 3;
    end else if (m_step == 0 || m_step == 3) begin
      m_w = 0;
      m_step = mv ? 1 : 0;
    end else if (!mv) begin
      m_step = 0;
    end else begin
      m_w++;
      m_step = ((m_w / FPS) % 2 == 0) ? 1 : 2;
    end
  endtask

  task automatic pix(int hc, int vc, bit hb, bit vb);
    exp_t e;
    int hm, vm;
    hm = hc & 4095;
    vm = vc & 4095;
    @(posedge clk);
    #1;
    vin.hcount = 12'(hm);
    vin.vcount = 12'(vm);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = 1'($urandom_range(1));
    vin.vsync  = 1'($urandom_range(1));
    vin.rgb    = 12'($urandom);
    e.cyc  = cyc;
    e.hc   = vin.hcount;
    e.vc   = vin.vcount;
    e.hs   = vin.hsync;
    e.vs   = vin.vsync;
    e.hb   = hb;
    e.vb   = vb;
    e.rgb  = model_rgb(hm, vm, hb, vb, vin.rgb);
    e.step = (hb || vb) ? -1 : m_step;
    q.push_back(e);
  endtask

  exp_t me;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      n_cmp++;
      if (vout.hcount != 0 || vout.vcount != 0 || vout.rgb != 0
          || vout.hsync || vout.vsync || vout.hblnk || vout.vblnk
          || anim_step != 0) begin
        n_bad++;
        $display("FAIL reset_zero t=%0t: got h=%0d v=%0d rgb=%h step=%0d, want all 0",
                 $time, vout.hcount, vout.vcount, vout.rgb, anim_step);
      end
    end else if (q.size() > 0) begin
      if (q[0].cyc + 2 < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL lost_pixel: issued cyc %0d never seen", q[0].cyc);
        void'(q.pop_front());
      end else if (q[0].cyc + 2 == cyc) begin
        me = q.pop_front();
        n_cmp++;
        if (vout.hcount != me.hc || vout.vcount != me.vc
            || vout.hsync != me.hs || vout.vsync != me.vs
            || vout.hblnk != me.hb || vout.vblnk != me.vb
            || vout.rgb != me.rgb
            || (me.step >= 0 && int'(anim_step) != me.step)) begin
          n_bad++;
          $display("FAIL pixel cyc=%0d: got h=%0d v=%0d s=%b%b b=%b%b rgb=%h step=%0d, want h=%0d v=%0d s=%b%b b=%b%b rgb=%h step=%0d",
                   me.cyc, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                   vout.hblnk, vout.vblnk, vout.rgb, anim_step,
                   me.hc, me.vc, me.hs, me.vs, me.hb, me.vb, me.rgb, me.step);
        end
      end
    end
  end

  initial begin
    st = IDLE;
    xpos = 12'd100;
    ypos = 12'd0;
    vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
    vin.hsync = 0; vin.vsync = 0; vin.hblnk = 0; vin.vblnk = 0;
    m_xp = 100; m_yp = 0; m_step = 0; m_face = 0; m_w = 0; m_blk = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int f = 0; f < NF; f++) begin
      if (f < 3) begin
        st = IDLE; m_xp = 100; m_yp = 0;
      end else if (f < 23) begin
        st = RIGHT1;
      end else if (f < 29) begin
        st = LEFT1;
      end else if (f < 32) begin
        st = RIGHT2;
      end else if (f < 34) begin
        st = LEFT2;
      end else if (f == 34) begin
        st = IDLE; m_xp = 4090; m_yp = 0;
      end else if (f < 100) begin
        if (f % 4 == 3) st = State'($urandom_range(4));
        m_xp = ($urandom_range(5) == 0) ? 4090 : int'($urandom_range(600));
        m_yp = ($urandom_range(3) == 0) ? int'($urandom_range(4095))
                                        : int'($urandom_range(60));
      end else begin
        st = IDLE;
        m_xp = int'($urandom_range(600));
        m_yp = int'($urandom_range(60));
      end
      xpos = 12'(m_xp);
      ypos = 12'(m_yp);
      pix(m_xp + 10, BY + m_yp + 30, 0, 0);
      pix(m_xp + 20, BY + m_yp + 30, 0, 0);
      pix(m_xp - 1, BY + m_yp + 30, 0, 0);
      if (f == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        pix(m_xp + 10, BY + m_yp + 30, 0, 0);
      end
      if (m_xp == 4090) begin
        for (int h = 0; h <= 40; h++)
          pix(h, BY + m_yp + int'($urandom_range(H - 1)), 0, 0);
      end
      for (int i = 0; i < NP; i++)
        pix(m_xp + int'($urandom_range(W + 8)) - 4,
            BY + m_yp + int'($urandom_range(H + 8)) - 4,
            $urandom_range(9) == 0, 0);
      for (int i = 0; i < 6; i++)
        pix(int'($urandom_range(799)), 500 + i,
            1'($urandom_range(1)), 1);
      model_tick(st);
    end
    repeat (6) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
